// File: rtl/gf256_inverse_iter.sv
`default_nettype none
// ============================================================================
//  Module      : gf256_inverse_iter
//  Description : Iterative GF(2^8) multiplicative inverter. Computes
//                x^254 mod {1,POLY} by MSB-first square-and-multiply, one
//                exponent bit per clock, with valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module gf256_inverse_iter #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] byte_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] byte_out,
    output logic       busy
);

    // ------------------------------------------------------------------------
    // State encoding and constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Exponent 254 = 8'b1111_1110, walked MSB first by cnt_q.
    localparam logic [7:0] C_EXP     = 8'hFE;
    localparam logic [7:0] C_ONE     = 8'h01;
    localparam logic [2:0] C_CNT_TOP = 3'd7;

    // ------------------------------------------------------------------------
    // Field arithmetic
    // ------------------------------------------------------------------------

    // Multiply by x and reduce once.
    function automatic logic [7:0] f_xtime(input logic [7:0] a);
        f_xtime = {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
    endfunction

    // General GF(2^8) multiply: shift-and-add with on-the-fly reduction.
    function automatic logic [7:0] f_gfmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = f_xtime(sh);
        end
        f_gfmul = acc;
    endfunction

    // Squaring is linear in GF(2): spread bits to even positions, then fold
    // the upper seven bits back down with the reduction polynomial.
    function automatic logic [7:0] f_gfsq(input logic [7:0] a);
        logic [15:0] s;
        s = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            s[2*i] = a[i];
        end
        for (int i = 14; i >= 8; i--) begin
            if (s[i]) begin
                s = s ^ ({8'h01, POLY} << (i - 8));
            end
        end
        f_gfsq = s[7:0];
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [7:0] op_q;
    logic [7:0] op_d;
    logic [7:0] acc_q;
    logic [7:0] acc_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // Datapath: one squarer feeding one multiplier.
    logic [7:0] sq_w;
    logic [7:0] mul_operand_w;
    logic [7:0] prod_w;

    assign sq_w          = f_gfsq(acc_q);
    assign mul_operand_w = C_EXP[cnt_q] ? op_q : C_ONE;
    assign prod_w        = f_gfmul(sq_w, mul_operand_w);

    // State register: synchronous active-low reset returns to IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next-state: capture on accept, one square-and-multiply per CALC cycle.
    always_comb begin
        op_d  = op_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d  = byte_in;
                    acc_d = C_ONE;
                    cnt_d = C_CNT_TOP;
                end
            end
            ST_CALC: begin
                acc_d = prod_w;
                cnt_d = cnt_q - 3'd1;
            end
            default: begin
                op_d  = op_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q  <= 8'h00;
            acc_q <= 8'h00;
            cnt_q <= 3'd0;
        end else begin
            op_q  <= op_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Outputs decode from state and registered accumulator only.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_CALC) || (state_q == ST_DONE);
        byte_out  = (state_q == ST_DONE) ? acc_q : 8'h00;
    end

endmodule
`default_nettype wire
